// File: rtl/fpu_issue_if.sv
// Bundle between the integer pipeline, the FPU and integer writeback for fpu_issue_unit.
// Handshakes: an instruction transfers on a cycle where in_valid & in_ready (in_ready never depends on in_valid);
// the FPU takes the presented head on a cycle where fpu_legl is high, and fpu_legl already folds in ~fpu_hazard.
interface fpu_issue_if;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_rs1_val;
  logic        in_ready;
  logic [31:0] fpu_inst;
  logic        fpu_legl;
  logic        fpu_hazard;
  logic [31:0] fpu_from_int;
  logic [31:0] fpu_to_int;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] stall_cnt;

  modport slave (
    input  in_valid, in_inst, in_rs1_val, fpu_hazard, fpu_to_int,
    output in_ready, fpu_inst, fpu_legl, fpu_from_int, wb_valid, wb_rd, wb_data, stall_cnt
  );

  modport master (
    output in_valid, in_inst, in_rs1_val, fpu_hazard, fpu_to_int,
    input  in_ready, fpu_inst, fpu_legl, fpu_from_int, wb_valid, wb_rd, wb_data, stall_cnt
  );
endinterface

// File: rtl/fpu_issue_unit.sv
// FP instruction issue buffer: FIFO to the FPU, operand alignment pipe and fixed-latency FP->int writeback.
// Optional hazard-stall counter enabled by defining FPU_ISSUE_STALL_CNT_EN.
module fpu_issue_unit #(
  parameter int DEPTH    = 4,
  parameter int RES_LAT  = 2,
  parameter int OPND_DLY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  fpu_issue_if.slave  io
);

  localparam int          AW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h00000013;

  typedef logic [AW:0] ptr_t;

  ptr_t        wptr_q, wptr_d;
  ptr_t        rptr_q, rptr_d;
  logic [31:0] inst_mem_q [DEPTH];
  logic [31:0] inst_mem_d [DEPTH];
  logic [31:0] rs1_mem_q  [DEPTH];
  logic [31:0] rs1_mem_d  [DEPTH];

  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [31:0] head_inst;
  logic [31:0] head_rs1;
  logic        head_is_fp;
  logic [4:0]  head_funct5;
  logic [4:0]  head_rd;
  logic        head_int_src;
  logic        head_int_dest;

  logic [OPND_DLY-1:0] opnd_vld_q, opnd_vld_d;
  logic [31:0]         opnd_val_q [OPND_DLY];
  logic [31:0]         opnd_val_d [OPND_DLY];
  logic [RES_LAT-1:0]  res_vld_q, res_vld_d;
  logic [4:0]          res_rd_q [RES_LAT];
  logic [4:0]          res_rd_d [RES_LAT];

  // Extra wrap bit distinguishes full from empty when the index bits match.
  always_comb begin
    empty     = (wptr_q == rptr_q);
    full      = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    push      = io.in_valid & ~full;
    pop       = ~empty & ~io.fpu_hazard;
    head_inst = inst_mem_q[rptr_q[AW-1:0]];
    head_rs1  = rs1_mem_q[rptr_q[AW-1:0]];
  end

  always_comb begin
    head_is_fp    = (head_inst[6:0] == 7'b1010011);
    head_funct5   = head_inst[31:27];
    head_rd       = head_inst[11:7];
    head_int_src  = head_is_fp && ((head_funct5 == 5'b11010) || (head_funct5 == 5'b11110));
    head_int_dest = head_is_fp && ((head_funct5 == 5'b10100) || (head_funct5 == 5'b11000) ||
                                   (head_funct5 == 5'b11100));
  end

  always_comb begin
    wptr_d     = wptr_q + ptr_t'(push);
    rptr_d     = rptr_q + ptr_t'(pop);
    inst_mem_d = inst_mem_q;
    rs1_mem_d  = rs1_mem_q;
    if (push) begin
      inst_mem_d[wptr_q[AW-1:0]] = io.in_inst;
      rs1_mem_d[wptr_q[AW-1:0]]  = io.in_rs1_val;
    end
  end

  // Tracking pipes advance every cycle so hazards never delay in-flight results.
  always_comb begin
    opnd_vld_d    = '0;
    opnd_val_d    = '{default: '0};
    opnd_vld_d[0] = pop & head_int_src;
    opnd_val_d[0] = (pop & head_int_src) ? head_rs1 : 32'h0;
    for (int i = 1; i < OPND_DLY; i++) begin
      opnd_vld_d[i] = opnd_vld_q[i-1];
      opnd_val_d[i] = opnd_val_q[i-1];
    end
  end

  always_comb begin
    res_vld_d    = '0;
    res_rd_d     = '{default: '0};
    res_vld_d[0] = pop & head_int_dest & (head_rd != 5'd0);
    res_rd_d[0]  = (pop & head_int_dest & (head_rd != 5'd0)) ? head_rd : 5'd0;
    for (int i = 1; i < RES_LAT; i++) begin
      res_vld_d[i] = res_vld_q[i-1];
      res_rd_d[i]  = res_rd_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      opnd_vld_q <= '0;
      opnd_val_q <= '{default: '0};
      res_vld_q  <= '0;
      res_rd_q   <= '{default: '0};
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      opnd_vld_q <= opnd_vld_d;
      opnd_val_q <= opnd_val_d;
      res_vld_q  <= res_vld_d;
      res_rd_q   <= res_rd_d;
    end
  end

  // Storage needs no reset: nothing is read until the pointers say an entry is live.
  always_ff @(posedge clk) begin
    inst_mem_q <= inst_mem_d;
    rs1_mem_q  <= rs1_mem_d;
  end

  assign io.in_ready     = ~full;
  assign io.fpu_inst     = empty ? NOP : head_inst;
  assign io.fpu_legl     = pop;
  assign io.fpu_from_int = opnd_vld_q[OPND_DLY-1] ? opnd_val_q[OPND_DLY-1] : 32'h0;
  assign io.wb_valid     = res_vld_q[RES_LAT-1];
  assign io.wb_rd        = res_rd_q[RES_LAT-1];
  assign io.wb_data      = res_vld_q[RES_LAT-1] ? io.fpu_to_int : 32'h0;

`ifdef FPU_ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (~empty & io.fpu_hazard & (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign io.stall_cnt = stall_cnt_q;
`else
  assign io.stall_cnt = 32'h0;
`endif

endmodule
